transmitter: RTL and testbench

//  Serialises parallel bytes into the single-wire bit-per-clock frame that the

---
 rtl/tx_frame_pkg.sv | 26 ++
 rtl/tx_hold_reg.sv | 42 ++++
 rtl/transmitter.sv | 136 +++++++++++++
 tb/tb_transmitter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/tx_frame_pkg.sv
// Shared frame definitions for the serial transmitter and its paired receiver.
// Holds line levels, frame length and the FSM state encodings.
package tx_frame_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int FRAME_BITS = DATA_WIDTH + 3;

    localparam logic IDLE_LEVEL  = 1'b0;
    localparam logic START_LEVEL = 1'b1;
    localparam logic STOP_LEVEL  = 1'b1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } tx_state_t;

endpackage

// File: rtl/tx_hold_reg.sv
// One-entry valid/ready holding buffer; push and pop may coincide in one edge.
// Zero latency to o_full; i_push_rdy deasserts while the entry is occupied.
module tx_hold_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push_vld,
    input  logic [W-1:0] i_push_dat,
    output logic         o_push_rdy,
    input  logic         i_pop,
    output logic         o_full,
    output logic [W-1:0] o_dat
);

    logic         r_full;
    logic [W-1:0] r_dat;
    logic         w_push;

    assign o_push_rdy = ~r_full;
    assign w_push     = i_push_vld & o_push_rdy;
    assign o_full     = r_full;
    assign o_dat      = r_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_dat  <= '0;
        end else begin
            if (w_push) begin
                r_dat <= i_push_dat;
            end
            // A push in the same edge as a pop refills the entry.
            if (w_push) begin
                r_full <= 1'b1;
            end else if (i_pop) begin
                r_full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/transmitter.sv
// Serialises bytes as start, LSB-first data, parity, stop; one bit per clock.
// First start bit one edge after the handshake; in_ready is low while the hold entry is full.
module transmitter #(
    parameter int DATA_WIDTH = tx_frame_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_byte,
    output logic                  in_ready,
    output logic                  out_bit,
    output logic                  busy,
    output logic                  done
);

    import tx_frame_pkg::*;

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    logic                  w_hold_full;
    logic [DATA_WIDTH-1:0] w_hold_dat;
    logic                  w_load;

    tx_hold_reg #(.W(DATA_WIDTH)) u_hold (
        .clk        (clk),
        .rst        (rst),
        .i_push_vld (in_valid),
        .i_push_dat (in_byte),
        .o_push_rdy (in_ready),
        .i_pop      (w_load),
        .o_full     (w_hold_full),
        .o_dat      (w_hold_dat)
    );

    // r_state names the frame field currently driven on the line.
    tx_state_t             r_state;
    logic                  r_out_bit;
    logic                  r_busy;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_cnt;
    logic                  r_par;

    tx_state_t             w_state_nxt;
    logic                  w_out_nxt;
    logic                  w_done_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [CW-1:0]         w_cnt_nxt;
    logic                  w_par_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_out_nxt   = IDLE_LEVEL;
        w_done_nxt  = 1'b0;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_par_nxt   = r_par;

        case (r_state)
            S_IDLE: begin
                if (w_hold_full) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_START;
                    w_out_nxt   = START_LEVEL;
                end
            end
            S_START: begin
                w_state_nxt = S_DATA;
                w_out_nxt   = r_shift[0];
                w_shift_nxt = r_shift >> 1;
                w_cnt_nxt   = '0;
            end
            S_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_PARITY;
                    w_out_nxt   = r_par;
                end else begin
                    w_out_nxt   = r_shift[0];
                    w_shift_nxt = r_shift >> 1;
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            S_PARITY: begin
                w_state_nxt = S_STOP;
                w_out_nxt   = STOP_LEVEL;
                w_done_nxt  = 1'b1;
            end
            S_STOP: begin
                if (w_hold_full) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_START;
                    w_out_nxt   = START_LEVEL;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_out_nxt   = IDLE_LEVEL;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Parity is taken from the whole byte at load, not from the draining shifter.
        if (w_load) begin
            w_shift_nxt = w_hold_dat;
            w_par_nxt   = ^w_hold_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_out_bit <= IDLE_LEVEL;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_par     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_out_bit <= w_out_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= w_done_nxt;
            r_shift   <= w_shift_nxt;
            r_cnt     <= w_cnt_nxt;
            r_par     <= w_par_nxt;
        end
    end

    assign out_bit = r_out_bit;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_transmitter.sv
// Directed and random bench for the transmitter against a queue-of-line-bits reference model.
module tb_transmitter;

    import tx_frame_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       in_ready;
    logic       out_bit;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    transmitter #(.DATA_WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_byte  (in_byte),
        .in_ready (in_ready),
        .out_bit  (out_bit),
        .busy     (busy),
        .done     (done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bit         line_q[$];
    logic [7:0] sent_q[$];
    logic       m_hold_full;
    logic [7:0] m_hold;
    logic       m_out;
    logic       m_busy;
    logic       m_done;
    logic       last_hs;

    logic [FRAME_BITS-1:0] hist;
    logic [7:0]  rx_byte;
    logic        rx_accept;
    logic [11:0] cap;
    logic [11:0] dcap;
    int nb;
    int run;
    int maxrun;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] b);
        line_q.push_back(START_LEVEL);
        for (int i = 0; i < 8; i++) line_q.push_back(b[i]);
        line_q.push_back(($countones(b) % 2) == 1);
        line_q.push_back(STOP_LEVEL);
    endtask

    // One clock: advance the model with the inputs held across the edge, then compare.
    task automatic step();
        logic hs;
        @(posedge clk);
        hs = 1'b0;
        if (rst) begin
            line_q.delete();
            sent_q.delete();
            m_hold_full = 1'b0;
            m_out  = 1'b0;
            m_busy = 1'b0;
            m_done = 1'b0;
        end else begin
            hs = in_valid && !m_hold_full;
            if (line_q.size() == 0 && m_hold_full) begin
                push_frame(m_hold);
                m_hold_full = 1'b0;
            end
            if (line_q.size() != 0) begin
                m_out  = line_q.pop_front();
                m_busy = 1'b1;
                m_done = (line_q.size() == 0);
            end else begin
                m_out  = 1'b0;
                m_busy = 1'b0;
                m_done = 1'b0;
            end
            if (hs) begin
                m_hold      = in_byte;
                m_hold_full = 1'b1;
                sent_q.push_back(in_byte);
            end
        end
        last_hs = hs;
        #1;
        check("out_bit",  32'(out_bit),  32'(m_out));
        check("busy",     32'(busy),     32'(m_busy));
        check("done",     32'(done),     32'(m_done));
        check("in_ready", 32'(in_ready), 32'(!m_hold_full));
        hist = {hist[FRAME_BITS-2:0], out_bit};
        if (done === 1'b1) begin
            for (int i = 0; i < 8; i++) rx_byte[i] = hist[FRAME_BITS-2-i];
            rx_accept = hist[1];
            if (sent_q.size() != 0) check("rx_byte", 32'(rx_byte), 32'(sent_q.pop_front()));
            else check("rx_spurious_done", 32'(done), 32'(0));
        end
    endtask

    task automatic tally();
        if (busy) begin
            nb++;
            run++;
            if (run > maxrun) maxrun = run;
        end else begin
            run = 0;
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_byte = 8'h5A;
        hist = '0; rx_byte = '0; rx_accept = 1'b0; last_hs = 1'b0;
        m_hold_full = 1'b0; m_hold = '0; m_out = 1'b0; m_busy = 1'b0; m_done = 1'b0;

        // Reset held with in_valid asserted.
        repeat (3) step();
        check("rst_out_bit",  32'(out_bit),  32'(0));
        check("rst_busy",     32'(busy),     32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        rst = 1'b0; in_valid = 1'b0;
        nb = 0; run = 0; maxrun = 0;
        repeat (6) begin step(); tally(); end
        check("rst_no_frame", 32'(nb), 32'(0));

        // Single 0xA7 from idle.
        in_valid = 1'b1; in_byte = 8'hA7;
        step();
        in_valid = 1'b0;
        cap = '0; dcap = '0;
        repeat (12) begin
            step();
            cap  = {cap[10:0], out_bit};
            dcap = {dcap[10:0], done};
        end
        check("a7_line", 32'(cap), 32'(12'b1111_0010_1110));
        check("a7_done", 32'(dcap), 32'(12'b0000_0000_0010));
        check("a7_rx_accept", 32'(rx_accept), 32'(1));

        // Back-to-back 0xA7, 0x01 with in_valid held.
        in_valid = 1'b1; in_byte = 8'hA7;
        step();
        check("b2b_rdy_before_load", 32'(in_ready), 32'(0));
        in_byte = 8'h01;
        nb = 0; run = 0; maxrun = 0;
        step(); tally();
        check("b2b_rdy_after_load", 32'(in_ready), 32'(1));
        step(); tally();
        check("b2b_second_taken", 32'(in_ready), 32'(0));
        in_valid = 1'b0;
        repeat (28) begin step(); tally(); end
        check("b2b_busy_cycles", 32'(nb), 32'(22));
        check("b2b_gapless", 32'(maxrun), 32'(22));

        // Even parity byte: line parity 0, receiver would reject.
        in_valid = 1'b1; in_byte = 8'h03;
        step();
        in_valid = 1'b0;
        cap = '0; dcap = '0;
        repeat (12) begin
            step();
            cap  = {cap[10:0], out_bit};
            dcap = {dcap[10:0], done};
        end
        check("even_parity_bit", 32'(cap[2]), 32'(0));
        check("even_stop_bit",   32'(cap[1]), 32'(1));
        check("even_done",       32'(dcap),   32'(12'b0000_0000_0010));
        check("even_rx_accept",  32'(rx_accept), 32'(0));

        // Reset during data bit 4 of 0xFF with 0x3C held.
        in_valid = 1'b1; in_byte = 8'hFF;
        step();
        in_byte = 8'h3C;
        step();
        step();
        in_valid = 1'b0;
        repeat (4) step();
        check("abort_bit4", 32'(out_bit), 32'(1));
        rst = 1'b1;
        step();
        check("abort_out_bit",  32'(out_bit),  32'(0));
        check("abort_busy",     32'(busy),     32'(0));
        check("abort_in_ready", 32'(in_ready), 32'(1));
        rst = 1'b0;
        nb = 0; run = 0; maxrun = 0;
        repeat (15) begin step(); tally(); end
        check("abort_held_dropped", 32'(nb), 32'(0));

        // Offer in the STOP cycle while hold is full.
        in_valid = 1'b1; in_byte = 8'h11;
        step();
        in_byte = 8'h22;
        step();
        step();
        in_valid = 1'b0;
        repeat (9) step();
        check("stop_offer_done", 32'(done), 32'(1));
        check("stop_offer_rdy",  32'(in_ready), 32'(0));
        in_valid = 1'b1; in_byte = 8'h33;
        step();
        check("stop_offer_rdy_next", 32'(in_ready), 32'(1));
        step();
        in_valid = 1'b0;
        check("stop_offer_taken", 32'(in_ready), 32'(0));
        repeat (30) step();
        check("stop_offer_drained", 32'(sent_q.size()), 32'(0));

        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if (!in_valid || last_hs) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_byte  = 8'($urandom);
            end
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; in_valid = 1'b0;
        repeat (30) step();
        check("rand_drained", 32'(sent_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
